// File: rtl/nmr_bstrm_multi_dpath.sv
// nmr_bstrm_multi_dpath: multi-channel gapless bitstream player for the NMR
// pulse sequencer. Command words are queued in a small FIFO and played back
// on an NCH-bit registered output vector with no dead cycles between commands.
// Optional status outputs (UNDERRUN, BAD_OP, LEVEL) are built only when the
// macro NMR_BSTRM_STATUS_EN is defined; otherwise they are tied to zero.
module nmr_bstrm_multi_dpath #(
    parameter  int NCH    = 4,
    parameter  int DATA_W = 120,
    parameter  int LEN_W  = 16,
    parameter  int DEPTH  = 8,
    localparam int CMD_W  = 2 + LEN_W + DATA_W,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [CMD_W-1:0] CMD,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             START,
    input  logic             ABORT,
    output logic [NCH-1:0]   OUT,
    output logic             DONE,
    output logic [LVL_W-1:0] LEVEL,
    output logic             UNDERRUN,
    output logic             BAD_OP
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] MAX_SLICES = LEN_W'(DATA_W / NCH);
    localparam logic [1:0] OP_END  = 2'b00;
    localparam logic [1:0] OP_HOLD = 2'b01;
    localparam logic [1:0] OP_PAT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             state;
    logic [CMD_W-1:0]   fifo_mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        fifo_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [CMD_W-1:0]   head;
    logic [1:0]         head_op;
    logic [LEN_W-1:0]   head_len;
    logic [DATA_W-1:0]  head_data;
    logic [LEN_W-1:0]   eff_len;
    logic [LEN_W-1:0]   remain;
    logic [DATA_W-1:0]  shreg;
    logic               is_pat;
    logic [NCH-1:0]     out_q;
    logic               done_q;

    // FIFO flags, head decode and the pop decision at command boundaries
    always_comb begin
        fifo_full  = (fifo_cnt == (AW+1)'(DEPTH));
        fifo_empty = (fifo_cnt == '0);
        push       = CMD_VALID && !fifo_full && !ABORT;
        head       = fifo_mem[rd_ptr];
        head_op    = head[CMD_W-1 -: 2];
        head_len   = head[DATA_W +: LEN_W];
        head_data  = head[DATA_W-1:0];
        pop        = !ABORT && !fifo_empty &&
                     ((state == ARMED) || ((state == RUN) && (remain == '0)));
        eff_len    = (head_len == '0) ? LEN_W'(1) : head_len;
        if ((head_op == OP_PAT) && (eff_len > MAX_SLICES)) begin
            eff_len = MAX_SLICES;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= CMD;
        end
    end

    // FIFO pointers and occupancy, flushed by ABORT
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (ABORT) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + (AW+1)'(1);
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - (AW+1)'(1);
            end
        end
    end

    // Playback FSM: loads the head on a boundary so the next vector follows with no gap
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            out_q  <= '0;
            done_q <= 1'b1;
            remain <= '0;
            shreg  <= '0;
            is_pat <= 1'b0;
        end else if (ABORT) begin
            state  <= IDLE;
            out_q  <= '0;
            done_q <= 1'b1;
            remain <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        state  <= ARMED;
                        done_q <= 1'b0;
                    end
                end
                ARMED, RUN: begin
                    if (pop) begin
                        case (head_op)
                            OP_HOLD, OP_PAT: begin
                                out_q  <= head_data[NCH-1:0];
                                shreg  <= head_data >> NCH;
                                is_pat <= (head_op == OP_PAT);
                                remain <= eff_len - LEN_W'(1);
                                state  <= RUN;
                            end
                            OP_END: begin
                                out_q  <= head_data[NCH-1:0];
                                done_q <= 1'b1;
                                state  <= IDLE;
                            end
                            default: begin
                                done_q <= 1'b1;
                                state  <= IDLE;
                            end
                        endcase
                    end else if (state == RUN) begin
                        if (remain != '0) begin
                            remain <= remain - LEN_W'(1);
                            if (is_pat) begin
                                out_q <= shreg[NCH-1:0];
                                shreg <= shreg >> NCH;
                            end
                        end else begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign OUT       = out_q;
    assign DONE      = done_q;
    assign CMD_READY = !fifo_full;

`ifdef NMR_BSTRM_STATUS_EN
    logic underrun_q;
    logic bad_op_q;
    logic underrun_ev;
    logic bad_op_ev;
    logic clear_ev;

    // Status events seen by the sticky flags
    always_comb begin
        underrun_ev = !ABORT && (state == RUN) && (remain == '0) && fifo_empty;
        bad_op_ev   = pop && (head_op == 2'b11);
        clear_ev    = !ABORT && (state == IDLE) && START;
    end

    // Sticky status flags, cleared when a new run is armed
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            underrun_q <= 1'b0;
            bad_op_q   <= 1'b0;
        end else if (clear_ev) begin
            underrun_q <= 1'b0;
            bad_op_q   <= 1'b0;
        end else begin
            if (underrun_ev) begin
                underrun_q <= 1'b1;
            end
            if (bad_op_ev) begin
                bad_op_q <= 1'b1;
            end
        end
    end

    assign UNDERRUN = underrun_q;
    assign BAD_OP   = bad_op_q;
    assign LEVEL    = fifo_cnt;
`else
    assign UNDERRUN = 1'b0;
    assign BAD_OP   = 1'b0;
    assign LEVEL    = '0;
`endif

endmodule

// File: tb/tb_nmr_bstrm_multi_dpath.sv
// tb_nmr_bstrm_multi_dpath: directed self-checking bench for nmr_bstrm_multi_dpath.
// Status expectations follow NMR_BSTRM_STATUS_EN (zero when it is undefined).
module tb_nmr_bstrm_multi_dpath;

    localparam int NCH    = 4;
    localparam int DATA_W = 120;
    localparam int LEN_W  = 16;
    localparam int DEPTH  = 8;
    localparam int CMD_W  = 2 + LEN_W + DATA_W;
    localparam int LVL_W  = 4;

`ifdef NMR_BSTRM_STATUS_EN
    localparam bit STATUS_ON = 1'b1;
`else
    localparam bit STATUS_ON = 1'b0;
`endif

    localparam logic [1:0] OP_END  = 2'b00;
    localparam logic [1:0] OP_HOLD = 2'b01;
    localparam logic [1:0] OP_PAT  = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic [CMD_W-1:0] CMD;
    logic             CMD_VALID;
    logic             CMD_READY;
    logic             START;
    logic             ABORT;
    logic [NCH-1:0]   OUT;
    logic             DONE;
    logic [LVL_W-1:0] LEVEL;
    logic             UNDERRUN;
    logic             BAD_OP;

    int checkCount = 0;
    int failCount  = 0;

    nmr_bstrm_multi_dpath #(
        .NCH(NCH), .DATA_W(DATA_W), .LEN_W(LEN_W), .DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .CMD(CMD), .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY), .START(START), .ABORT(ABORT), .OUT(OUT),
        .DONE(DONE), .LEVEL(LEVEL), .UNDERRUN(UNDERRUN), .BAD_OP(BAD_OP)
    );

    // 10 ns clock
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [CMD_W-1:0] mkCmd(input logic [1:0] op, input logic [LEN_W-1:0] len,
                                              input logic [DATA_W-1:0] data);
        return {op, len, data};
    endfunction

    // Push one word: called at a negedge, accepted at the following posedge
    task automatic applyStimulus(input logic [1:0] op, input logic [LEN_W-1:0] len,
                                 input logic [DATA_W-1:0] data);
        CMD       = mkCmd(op, len, data);
        CMD_VALID = 1'b1;
        @(negedge CLK);
        CMD_VALID = 1'b0;
    endtask

    task automatic pulseStart();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic expectOut(input string tag, input logic [NCH-1:0] value);
        @(negedge CLK);
        checkOutput(tag, 32'(OUT), 32'(value));
    endtask

    initial begin
        logic [DATA_W-1:0] clampData;
        int n;

        RST_N = 1'b0; CMD = '0; CMD_VALID = 1'b0; START = 1'b0; ABORT = 1'b0;
        #12;
        $display("[TB] reset values");
        checkOutput("rst_out",      32'(OUT),       32'h0);
        checkOutput("rst_done",     32'(DONE),      32'h1);
        checkOutput("rst_ready",    32'(CMD_READY), 32'h1);
        checkOutput("rst_level",    32'(LEVEL),     32'h0);
        checkOutput("rst_underrun", 32'(UNDERRUN),  32'h0);
        checkOutput("rst_bad_op",   32'(BAD_OP),    32'h0);
        @(negedge CLK);
        RST_N = 1'b1;

        $display("[TB] gapless HOLD sequence");
        applyStimulus(OP_HOLD, 16'd3, 120'hA);
        applyStimulus(OP_HOLD, 16'd2, 120'h5);
        applyStimulus(OP_END,  16'd0, 120'h0);
        checkOutput("preload_level", 32'(LEVEL), STATUS_ON ? 32'd3 : 32'd0);
        pulseStart();
        checkOutput("armed_done", 32'(DONE), 32'h0);
        expectOut("hold_a0", 4'hA);
        expectOut("hold_a1", 4'hA);
        expectOut("hold_a2", 4'hA);
        expectOut("hold_50", 4'h5);
        expectOut("hold_51", 4'h5);
        checkOutput("hold_running_done", 32'(DONE), 32'h0);
        expectOut("hold_end", 4'h0);
        checkOutput("hold_end_done", 32'(DONE), 32'h1);

        $display("[TB] PATTERN len=4");
        applyStimulus(OP_PAT, 16'd4, 120'h4321);
        applyStimulus(OP_END, 16'd0, 120'h0);
        pulseStart();
        expectOut("pat_s0", 4'h1);
        expectOut("pat_s1", 4'h2);
        expectOut("pat_s2", 4'h3);
        expectOut("pat_s3", 4'h4);
        expectOut("pat_end", 4'h0);
        checkOutput("pat_done", 32'(DONE), 32'h1);

        $display("[TB] PATTERN len=100 clamps to 30 slices");
        clampData = '0;
        for (int k = 0; k < 30; k++) begin
            clampData[k*NCH +: NCH] = 4'((k % 15) + 1);
        end
        applyStimulus(OP_PAT, 16'd100, clampData);
        applyStimulus(OP_END, 16'd0, 120'h0);
        pulseStart();
        n = 0;
        while (n < 200) begin
            @(negedge CLK);
            if (DONE) break;
            if (n < 30) checkOutput("clamp_slice", 32'(OUT), 32'((n % 15) + 1));
            n++;
        end
        checkOutput("clamp_len", 32'(n), 32'd30);
        checkOutput("clamp_end_out", 32'(OUT), 32'h0);

        $display("[TB] zero length HOLD plays one cycle, END drives its level");
        applyStimulus(OP_HOLD, 16'd0, 120'h9);
        applyStimulus(OP_END,  16'd0, 120'h6);
        pulseStart();
        expectOut("len0_hold", 4'h9);
        expectOut("end_level", 4'h6);
        checkOutput("end_level_done", 32'(DONE), 32'h1);

        $display("[TB] underrun");
        applyStimulus(OP_HOLD, 16'd2, 120'hF);
        pulseStart();
        expectOut("ur_f0", 4'hF);
        checkOutput("ur_done0", 32'(DONE), 32'h0);
        expectOut("ur_f1", 4'hF);
        checkOutput("ur_done1", 32'(DONE), 32'h0);
        expectOut("ur_hold", 4'hF);
        checkOutput("ur_done", 32'(DONE), 32'h1);
        checkOutput("ur_flag", 32'(UNDERRUN), STATUS_ON ? 32'h1 : 32'h0);
        expectOut("ur_stays", 4'hF);

        $display("[TB] reserved op");
        applyStimulus(OP_HOLD, 16'd2, 120'h3);
        applyStimulus(OP_RSV,  16'd5, 120'h7);
        pulseStart();
        checkOutput("start_clears_underrun", 32'(UNDERRUN), 32'h0);
        expectOut("rsv_h0", 4'h3);
        expectOut("rsv_h1", 4'h3);
        expectOut("rsv_out", 4'h3);
        checkOutput("rsv_done", 32'(DONE), 32'h1);
        checkOutput("rsv_bad_op", 32'(BAD_OP), STATUS_ON ? 32'h1 : 32'h0);

        $display("[TB] backpressure");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(OP_HOLD, 16'd1, 120'(i + 1));
        end
        checkOutput("bp_ready", 32'(CMD_READY), 32'h0);
        checkOutput("bp_level", 32'(LEVEL), STATUS_ON ? 32'd8 : 32'd0);
        CMD = mkCmd(OP_END, 16'd0, 120'hD);
        CMD_VALID = 1'b1;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        checkOutput("bp_level_extra", 32'(LEVEL), STATUS_ON ? 32'd8 : 32'd0);
        pulseStart();
        checkOutput("bp_start_clears_bad_op", 32'(BAD_OP), 32'h0);
        checkOutput("bp_ready_armed", 32'(CMD_READY), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            expectOut("bp_play", 4'(i + 1));
        end
        expectOut("bp_no_extra", 4'h8);
        checkOutput("bp_underrun_done", 32'(DONE), 32'h1);
        checkOutput("bp_level_empty", 32'(LEVEL), 32'h0);

        $display("[TB] abort mid-PATTERN with simultaneous push");
        applyStimulus(OP_PAT, 16'd10, 120'h4321);
        applyStimulus(OP_END, 16'd0, 120'h5);
        pulseStart();
        expectOut("ab_s0", 4'h1);
        expectOut("ab_s1", 4'h2);
        expectOut("ab_s2", 4'h3);
        checkOutput("ab_level_before", 32'(LEVEL), STATUS_ON ? 32'd1 : 32'd0);
        ABORT = 1'b1;
        CMD = mkCmd(OP_HOLD, 16'd1, 120'hE);
        CMD_VALID = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        CMD_VALID = 1'b0;
        checkOutput("ab_out", 32'(OUT), 32'h0);
        checkOutput("ab_done", 32'(DONE), 32'h1);
        checkOutput("ab_level", 32'(LEVEL), 32'h0);
        checkOutput("ab_ready", 32'(CMD_READY), 32'h1);
        pulseStart();
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("ab_push_dropped_out", 32'(OUT), 32'h0);
        checkOutput("ab_push_dropped_done", 32'(DONE), 32'h0);
        applyStimulus(OP_END, 16'd0, 120'h2);
        expectOut("ab_late_end", 4'h2);
        checkOutput("ab_late_done", 32'(DONE), 32'h1);

        $display("[TB] reset mid-HOLD");
        applyStimulus(OP_HOLD, 16'd20, 120'hC);
        applyStimulus(OP_HOLD, 16'd1, 120'h1);
        pulseStart();
        expectOut("rh_c0", 4'hC);
        expectOut("rh_c1", 4'hC);
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("rh_out", 32'(OUT), 32'h0);
        checkOutput("rh_done", 32'(DONE), 32'h1);
        checkOutput("rh_level", 32'(LEVEL), 32'h0);
        checkOutput("rh_ready", 32'(CMD_READY), 32'h1);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("rh_idle_out", 32'(OUT), 32'h0);
        checkOutput("rh_idle_done", 32'(DONE), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/nmr_bstrm_multi_dpath.md
# nmr_bstrm_multi_dpath

Multi-channel, gapless successor to the single-bit bitstream datapath in the NMR pulse-sequencer chain. It accepts command words through a valid/ready push interface into an internal command FIFO, then plays them back on an NCH-bit output vector with no dead cycles between commands. Each command either holds a constant vector for a programmed length or shifts out a multi-channel pattern. The block sits between the sequence-SRAM reader and the TX/gating output pins.

## Interface
- NCH, 4: number of output channels; DATA_W % NCH must be 0.
- DATA_W, 120: command data field width.
- LEN_W, 16: command length field width.
- DEPTH, 8: command FIFO depth; power of 2, ≥ 2.
- CMD_W (derived): 2 + LEN_W + DATA_W; command layout is {op[1:0], len[LEN_W-1:0], data[DATA_W-1:0]}.
- CLK  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  reset, asynchronous and active-low.
- CMD  input  CMD_W  command word.
- CMD_VALID  input  1  CMD is presented this cycle.
- CMD_READY  output  1  equals !fifo_full; the word is accepted on an edge where VALID && READY.
- START  input  1  one-cycle arm request; sampled in IDLE only.
- ABORT  input  1  synchronous abort; highest priority.
- OUT  output  NCH  registered channel vector.
- DONE  output  1  high in IDLE.
- LEVEL  output  $clog2(DEPTH)+1  FIFO occupancy.
- UNDERRUN  output  1  sticky: FIFO was empty at a command boundary.
- BAD_OP  output  1  sticky: reserved op was executed.

## Operation
- Op codes: 2'b00 END, 2'b01 HOLD, 2'b10 PATTERN, 2'b11 reserved.
- HOLD drives OUT = data[NCH-1:0] for max(len,1) cycles.
- PATTERN drives slice k = data[k*NCH +: NCH] in cycle k, LSB slice first, for max(len,1) cycles.
  - len is clamped to DATA_W/NCH; the default clamp is 30.
- END drives OUT = data[NCH-1:0] as the final idle level. The block then goes to IDLE with DONE=1.
- Reserved op: treated as END with OUT unchanged; BAD_OP is set.
- States:
  - IDLE: START=1 moves to ARMED. UNDERRUN and BAD_OP are cleared on START.
  - ARMED: waits while the FIFO is empty. When the FIFO is not empty, it pops the head, loads it, and moves to RUN.
  - RUN: a down-counter tracks the remaining cycles of the current command. On the last cycle:
    - if the FIFO is not empty, the next head is popped and loaded so that its first vector appears on the following cycle (gapless);
    - if the FIFO is empty, UNDERRUN is set, OUT holds its last value, DONE is set, and the state goes to IDLE.
- ABORT=1 at an edge, in any state:
  - the FIFO is flushed (LEVEL=0), OUT=0, DONE=1, state goes to IDLE;
  - any simultaneous push is dropped.
- The FIFO accepts pushes in every state, including IDLE, so a sequence can be preloaded.
- Reset, asynchronous on RST_N low:
  - OUT=0, DONE=1, LEVEL=0, UNDERRUN=0, BAD_OP=0, state IDLE, FIFO empty;
  - CMD_READY=1 once the FIFO is empty.
- Reset mid-run has the same effect as the reset above, applied immediately.

## Timing
- START at edge E0 moves the block to ARMED.
- If the FIFO is not empty at E1 = E0+1, the head is loaded at E1 and its first vector is on OUT after E1.
  - Latency is START→OUT change in 2 edges.
- A push accepted at edge Ep is poppable at edge Ep+1 or later, never at the same edge.
- CMD_READY is combinational from the full flag. When the FIFO is full, READY=0 even if a pop occurs on the same edge.
- A command of length L occupies exactly L consecutive OUT cycles.
- The command boundary pop and the load of the next command happen on the same edge: 0 idle cycles between commands.
- LEVEL updates on the edge of a push or pop. A simultaneous push and pop leaves LEVEL unchanged.
- DONE rises on the edge that loads END, loads a reserved op, detects underrun, or samples ABORT.
- DONE falls on the edge leaving IDLE.

## Configuration
- NMR_BSTRM_STATUS_EN:
  - Defined: UNDERRUN, BAD_OP and LEVEL are implemented as described.
  - Undefined: UNDERRUN, BAD_OP and LEVEL are tied to 0 and their logic is removed. Functional OUT/DONE behaviour is identical, including the underrun stop and the reserved-op stop.

## Test plan
- Gapless HOLD sequence:
  - Stimulus: preload HOLD(len=3,data=4'hA), HOLD(len=2,data=4'h5), END(data=4'h0), then START.
  - Required: OUT = A,A,A,5,5,0, then DONE=1; no gap cycles.
- PATTERN:
  - Stimulus: PATTERN(len=4, data low 16 bits=16'h4321) followed by END.
  - Required: OUT = 1,2,3,4 then 0.
  - Stimulus: the same pattern with len=100.
  - Required: it plays exactly 30 slices (the clamp).
- Underrun:
  - Stimulus: a single HOLD(len=2,data=4'hF), no END, START.
  - Required: OUT=F for 2 cycles and stays F; UNDERRUN=1, DONE=1.
- Backpressure:
  - Stimulus: push DEPTH+1 words in IDLE.
  - Required: CMD_READY=0 after DEPTH pushes; LEVEL=DEPTH; the extra word is not accepted.
- Abort and reset:
  - Stimulus: ABORT mid-PATTERN with a simultaneous push.
  - Required: next cycle OUT=0, LEVEL=0, DONE=1, pushed word absent.
  - Stimulus: RST_N low mid-HOLD.
  - Required: OUT=0 immediately.
- Reserved op:
  - Stimulus: op=2'b11 after HOLD(data=4'h3).
  - Required: OUT stays 3, BAD_OP=1, DONE=1.
  - Required: with NMR_BSTRM_STATUS_EN undefined, BAD_OP stays 0.
